tdm_demux1x4: RTL

//  Receive end of the 4:1 time-division link: takes one serial word stream, in which four

---
 rtl/tdm_demux_pkg.sv | 23 ++
 rtl/tdm_sync_fsm.sv | 99 +++++++++
 rtl/tdm_demux1x4.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tdm_demux_pkg.sv
// Purpose : shared types and constants for the 1:4 TDM receive path.
//   sync_state_e : frame-sync state (HUNT = searching for marker, LOCKED = in sync)
//   slot_t       : position of a beat inside a four-slot frame
//   slot_inc     : wrapping slot increment (3 -> 0)
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sync_state_e;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t FIRST_SLOT = 2'd0;
    localparam slot_t LAST_SLOT  = slot_t'(NUM_SLOTS - 1);

    function automatic slot_t slot_inc(input slot_t s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/tdm_sync_fsm.sv
// Purpose : frame-sync tracker for the TDM receiver. Decides, for every
//           accepted input beat, whether it extends the current frame,
//           starts a new frame, or is thrown away. Flywheels through up to
//           SYNC_LOSS-1 consecutive missing start-of-frame markers.
// Ports   :
//   clk, rst   clock and synchronous active-high reset
//   in_valid   beat qualifier
//   in_sof     start-of-frame marker of the current beat
//   slot       slot the next beat would occupy (owned by the top level)
//   accept     strobe: store beat at 'slot' and advance slot normally
//   restart    strobe: beat becomes slot 0 of a fresh frame, partial frame lost
//   drop       strobe: beat discarded
//   locked     registered lock indication
//   sof_err    registered one-cycle marker-violation pulse
module tdm_sync_fsm
    import tdm_demux_pkg::*;
#(
    parameter int SYNC_LOSS = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  logic  in_sof,
    input  slot_t slot,
    output logic  accept,
    output logic  restart,
    output logic  drop,
    output logic  locked,
    output logic  sof_err
);

    localparam int MW = $clog2(SYNC_LOSS + 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(SYNC_LOSS);

    sync_state_e   state_q, state_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          sof_err_q, sof_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            miss_q    <= '0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            miss_q    <= miss_d;
            sof_err_q <= sof_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        miss_d    = miss_q;
        sof_err_d = 1'b0;
        accept    = 1'b0;
        restart   = 1'b0;
        drop      = 1'b0;

        if (in_valid) begin
            if (state_q == HUNT) begin
                if (in_sof) begin
                    restart = 1'b1;
                    state_d = LOCKED;
                    miss_d  = '0;
                end else begin
                    drop = 1'b1;
                end
            end else if (slot == FIRST_SLOT) begin
                if (in_sof) begin
                    accept = 1'b1;
                    miss_d = '0;
                end else begin
                    // Missing marker where one was due: ride through it
                    // until SYNC_LOSS consecutive misses have been seen.
                    sof_err_d = 1'b1;
                    if ((int'(miss_q) + 1) < SYNC_LOSS) begin
                        accept = 1'b1;
                        miss_d = (miss_q == MISS_MAX) ? miss_q : miss_q + 1'b1;
                    end else begin
                        drop    = 1'b1;
                        state_d = HUNT;
                        miss_d  = '0;
                    end
                end
            end else if (in_sof) begin
                // Early marker: trust it and resynchronise on this beat.
                // The miss counter is left alone since the marker did arrive.
                sof_err_d = 1'b1;
                restart   = 1'b1;
            end else begin
                accept = 1'b1;
            end
        end
    end

    assign locked  = (state_q == LOCKED);
    assign sof_err = sof_err_q;

endmodule

// File: rtl/tdm_demux1x4.sv
// Purpose : receive end of a 4:1 TDM link. De-interleaves a serial word
//           stream (slots 0..3 -> a..d) into four registered outputs that
//           are updated atomically once per complete frame.
// Ports   :
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_data/in_sof  input beat, data word, start-of-frame marker
//   out_a..out_d          words of the last complete frame
//   out_valid             one-cycle pulse when out_a..out_d were just updated
//   locked                frame sync held
//   sof_err               one-cycle pulse on a frame-marker violation
module tdm_demux1x4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SYNC_LOSS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             out_valid,
    output logic             locked,
    output logic             sof_err
);

    logic accept, restart, drop;

    slot_t            slot_q, slot_d;
    logic [WIDTH-1:0] shadow_a_q, shadow_a_d;
    logic [WIDTH-1:0] shadow_b_q, shadow_b_d;
    logic [WIDTH-1:0] shadow_c_q, shadow_c_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic [WIDTH-1:0] out_d_q, out_d_d;
    logic             out_valid_q, out_valid_d;

    tdm_sync_fsm #(
        .SYNC_LOSS (SYNC_LOSS)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .slot     (slot_q),
        .accept   (accept),
        .restart  (restart),
        .drop     (drop),
        .locked   (locked),
        .sof_err  (sof_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= FIRST_SLOT;
            shadow_a_q  <= '0;
            shadow_b_q  <= '0;
            shadow_c_q  <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            shadow_a_q  <= shadow_a_d;
            shadow_b_q  <= shadow_b_d;
            shadow_c_q  <= shadow_c_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        slot_d      = slot_q;
        shadow_a_d  = shadow_a_q;
        shadow_b_d  = shadow_b_q;
        shadow_c_d  = shadow_c_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_d_d     = out_d_q;
        out_valid_d = 1'b0;

        if (restart) begin
            // Stale shadows b/c are simply overwritten as the new frame fills.
            shadow_a_d = in_data;
            slot_d     = slot_inc(FIRST_SLOT);
        end else if (accept) begin
            case (slot_q)
                2'd0: shadow_a_d = in_data;
                2'd1: shadow_b_d = in_data;
                2'd2: shadow_c_d = in_data;
                default: begin
                    // Last slot: publish the whole frame on one edge so the
                    // outputs are never seen half-updated.
                    out_a_d     = shadow_a_q;
                    out_b_d     = shadow_b_q;
                    out_c_d     = shadow_c_q;
                    out_d_d     = in_data;
                    out_valid_d = 1'b1;
                end
            endcase
            slot_d = slot_inc(slot_q);
        end
        // drop: nothing changes on the data path.
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign out_valid = out_valid_q;

endmodule
